// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Sequences every access to the shared external SRAM. It arbitrates between
//   the read-only SNES cartridge bus and the read/write AVR side. It drives
//   registered SRAM strobes, the latched address and the write-data enable,
//   and stretches each access by ACCESS_CYCLES wait states.
//
// Ports
//   clk, reset_n              system clock (rising edge), async active-low reset
//   snes_mode                 1: SNES has priority, AVR is served opportunistically
//                             0: AVR exclusive, SNES is ignored
//   snes_req/addr/rdata/ack   SNES read port (level request, 1-cycle ack)
//   avr_req/we/addr/wdata     AVR request port (level request)
//   avr_rdata/ack/busy        AVR results; busy = request pending, not yet granted
//   sram_addr/din/dout        SRAM address and data pins
//   sram_dout_en              tristate enable for sram_dout
//   sram_ce_n/oe_n/we_n       registered SRAM strobes
//   debug                     {grant_avr, grant_snes, starve_cnt[2:0], state[2:0]}
//
// Handshake (both requesters): req is a level held until the matching ack.
// The ack is a single-cycle pulse in DONE. The requester drops req on the
// edge after the ack. Requests are only arbitrated in IDLE, so a request that
// is still high during DONE is ignored. If it is still high in the following
// IDLE, it starts a new access. Address, direction and write data are latched
// at the grant edge, so requester inputs are don't-care after the grant.

module sram_arbiter #(
   parameter int AWIDTH        = 21,
   parameter int DWIDTH        = 8,
   parameter int ACCESS_CYCLES = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              snes_mode,
   input  logic              snes_req,
   input  logic [AWIDTH-1:0] snes_addr,
   output logic [DWIDTH-1:0] snes_rdata,
   output logic              snes_ack,
   input  logic              avr_req,
   input  logic              avr_we,
   input  logic [AWIDTH-1:0] avr_addr,
   input  logic [DWIDTH-1:0] avr_wdata,
   output logic [DWIDTH-1:0] avr_rdata,
   output logic              avr_ack,
   output logic              avr_busy,
   output logic [AWIDTH-1:0] sram_addr,
   input  logic [DWIDTH-1:0] sram_din,
   output logic [DWIDTH-1:0] sram_dout,
   output logic              sram_dout_en,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [7:0]        debug
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_SETUP = 3'd1,
      RD_WAIT  = 3'd2,
      WR_SETUP = 3'd3,
      WR_PULSE = 3'd4,
      WR_HOLD  = 3'd5,
      DONE     = 3'd6
   } state_t;

   // A zero wait-state count is not meaningful. It is clamped to one so that
   // the wait counter can never underflow.
   localparam int         WAIT_CYCLES = (ACCESS_CYCLES < 1) ? 1 : ACCESS_CYCLES;
   localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_CYCLES - 1);
   localparam logic [2:0] STARVE_MAX  = 3'(STARVE_LIMIT);

   state_t     state;
   state_t     next_state;
   logic [3:0] wait_cnt;
   logic       last_wait;
   logic [2:0] starve_cnt;
   logic       grant_avr;
   logic       grant_snes;
   logic       pick_avr;
   logic       pick_snes;

   // Strobe and enable values for the next cycle. They are decoded from
   // next_state so that the registered pins line up with the state register.
   logic       ce_d;
   logic       oe_d;
   logic       we_d;
   logic       en_d;

   assign last_wait = (wait_cnt == 4'd0);
   assign debug     = {grant_avr, grant_snes, starve_cnt, state};

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ------------------------------------------------------------------
   // Arbitration, next state and strobe decode
   // ------------------------------------------------------------------
   always_comb begin
      next_state = state;
      pick_avr   = 1'b0;
      pick_snes  = 1'b0;
      ce_d       = 1'b0;
      oe_d       = 1'b0;
      we_d       = 1'b0;
      en_d       = 1'b0;

      case (state)
         IDLE: begin
            // SNES wins ties in SNES mode. The exception is when the AVR has
            // already been passed over STARVE_LIMIT times in a row.
            if (snes_mode && snes_req &&
                !(avr_req && (starve_cnt == STARVE_MAX))) begin
               pick_snes = 1'b1;
            end else if (avr_req) begin
               pick_avr = 1'b1;
            end

            if (pick_snes) begin
               next_state = RD_SETUP;
            end else if (pick_avr) begin
               next_state = avr_we ? WR_SETUP : RD_SETUP;
            end
         end
         RD_SETUP: next_state = RD_WAIT;
         RD_WAIT:  if (last_wait) next_state = DONE;
         WR_SETUP: next_state = WR_PULSE;
         WR_PULSE: if (last_wait) next_state = WR_HOLD;
         WR_HOLD:  next_state = DONE;
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase

      case (next_state)
         RD_SETUP, RD_WAIT: begin
            ce_d = 1'b1;
            oe_d = 1'b1;
         end
         WR_SETUP, WR_HOLD: begin
            ce_d = 1'b1;
            en_d = 1'b1;
         end
         WR_PULSE: begin
            ce_d = 1'b1;
            en_d = 1'b1;
            we_d = 1'b1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Wait-state counter: it is preloaded outside the wait states and counts
   // down inside them. Zero marks the last wait cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= WAIT_LOAD;
      end else if ((state == RD_WAIT) || (state == WR_PULSE)) begin
         if (!last_wait) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
      end else begin
         wait_cnt <= WAIT_LOAD;
      end
   end

   // ------------------------------------------------------------------
   // Grant bookkeeping: owner flags, latched address/data, starvation count
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_avr  <= 1'b0;
         grant_snes <= 1'b0;
         starve_cnt <= 3'd0;
         sram_addr  <= '0;
         sram_dout  <= '0;
      end else if (state == IDLE) begin
         if (pick_snes) begin
            grant_snes <= 1'b1;
            sram_addr  <= snes_addr;
         end else if (pick_avr) begin
            grant_avr  <= 1'b1;
            sram_addr  <= avr_addr;
            sram_dout  <= avr_wdata;
         end

         // The count tracks SNES grants that were made over a waiting AVR.
         if (pick_avr || !avr_req) begin
            starve_cnt <= 3'd0;
         end else if (pick_snes && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 3'd1;
         end
      end else if (state == DONE) begin
         grant_avr  <= 1'b0;
         grant_snes <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Registered pins, acks, busy and read data capture
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_dout_en <= 1'b0;
         snes_ack     <= 1'b0;
         avr_ack      <= 1'b0;
         avr_busy     <= 1'b0;
         snes_rdata   <= '0;
         avr_rdata    <= '0;
      end else begin
         sram_ce_n    <= ~ce_d;
         sram_oe_n    <= ~oe_d;
         sram_we_n    <= ~we_d;
         sram_dout_en <= en_d;
         snes_ack     <= (next_state == DONE) && grant_snes;
         avr_ack      <= (next_state == DONE) && grant_avr;
         // The AVR counts as served from its grant edge through DONE.
         avr_busy     <= avr_req && !(pick_avr || grant_avr);

         if ((state == RD_WAIT) && last_wait) begin
            if (grant_snes) begin
               snes_rdata <= sram_din;
            end else if (grant_avr) begin
               avr_rdata <= sram_din;
            end
         end
      end
   end

endmodule
